// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one trial subtract per cycle.
// Ports: clk, rst_n, start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] q_shift;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             last;

  // prem never exceeds divisor after a restore, so its MSB is
  // always shifted out as zero.
  logic unused_prem_msb;
  assign unused_prem_msb = prem[WIDTH];

  assign shifted = {prem[WIDTH-1:0], dvd_shift[WIDTH-1]};

  // Subtract as add of inverted divisor with carry-in of one.
  assign trial = shifted + {1'b1, ~dvs} + {{WIDTH{1'b0}}, 1'b1};

  assign q_bit     = ~trial[WIDTH];
  assign prem_next = q_bit ? trial : shifted;
  assign q_next    = {q_shift[WIDTH-2:0], q_bit};

  assign accept = start && (state != CALC);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_shift   <= '0;
      dvs         <= '0;
      prem        <= '0;
      q_shift     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          dvd_shift   <= dividend;
          dvs         <= divisor;
          prem        <= '0;
          q_shift     <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            state <= CALC;
          end
        end
        (state == CALC): begin
          prem      <= prem_next;
          dvd_shift <= {dvd_shift[WIDTH-2:0], 1'b0};
          q_shift   <= q_next;
          cnt       <= cnt + 1'b1;
          if (last) begin
            quotient  <= q_next;
            remainder <= prem_next[WIDTH-1:0];
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
